// File: rtl/uart_csr_bridge_pkg.sv
// uart_csr_bridge shared constants and FSM state encoding.
// Frame command/response bytes used by the bridge and its bench.
package uart_csr_bridge_pkg;

  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ADDR = 3'd1;
  localparam state_t ST_DATA = 3'd2;
  localparam state_t ST_REQ  = 3'd3;
  localparam state_t ST_WAIT = 3'd4;
  localparam state_t ST_TX   = 3'd5;

endpackage

// File: rtl/uart_byte_io.sv
// uart_byte_io: 8N1 byte receiver (mid-bit sampler) and transmitter.
// tx_busy drops in the final stop cycle so bytes can go back-to-back.
module uart_byte_io #(
  parameter int CLKS_PER_BIT = 1085
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s1, rx_s2, rx_s3;
  logic          rx_on;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_sh;

  logic          tx_on;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;
  logic          tx_last;

  // Two-flop synchronizer plus one delay tap for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // Hunt for a falling edge, then sample start, 8 data and stop bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_on  <= 1'b0;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else if (!rx_on) begin
      if (rx_s3 && !rx_s2) begin
        rx_on  <= 1'b1;
        rx_cnt <= HALF;
        rx_bit <= '0;
      end
    end else if (rx_cnt != '0) begin
      rx_cnt <= rx_cnt - 1'b1;
    end else begin
      rx_cnt <= FULL;
      rx_bit <= rx_bit + 4'd1;
      if (rx_bit == 4'd0) begin
        if (rx_s2) rx_on <= 1'b0;
      end else if (rx_bit == 4'd9) begin
        rx_on <= 1'b0;
      end else begin
        rx_sh <= {rx_s2, rx_sh[7:1]};
      end
    end
  end

  assign rx_byte  = rx_sh;
  assign rx_valid = rx_on && (rx_cnt == '0) &&
                    (rx_bit == 4'd9) && rx_s2;

  assign tx_last = tx_on && (tx_cnt == '0) && (tx_bit == 4'd9);
  assign tx_busy = tx_on && !tx_last;

  // Shift out start, data LSB first, stop; reload on tx_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx <= 1'b1;
      tx_on   <= 1'b0;
      tx_cnt  <= '0;
      tx_bit  <= '0;
      tx_sh   <= '1;
    end else if (tx_start && !tx_busy) begin
      uart_tx <= 1'b0;
      tx_sh   <= {1'b1, tx_byte};
      tx_on   <= 1'b1;
      tx_cnt  <= FULL;
      tx_bit  <= '0;
    end else if (tx_on) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_last) begin
        tx_on   <= 1'b0;
        uart_tx <= 1'b1;
      end else begin
        uart_tx <= tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[8:1]};
        tx_cnt  <= FULL;
        tx_bit  <= tx_bit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/uart_csr_bridge.sv
// uart_csr_bridge: UART command frames to single CSR reads/writes.
// Optional inter-byte timeout: define UART_CSR_BRIDGE_TIMEOUT_EN.
module uart_csr_bridge
  import uart_csr_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1085,
  parameter int ADDR_W       = 16,
  parameter int GAP_CYC      = 2_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              s_cpuif_req,
  output logic              s_cpuif_req_is_wr,
  output logic [ADDR_W-1:0] s_cpuif_addr,
  output logic [31:0]       s_cpuif_wr_data,
  output logic [31:0]       s_cpuif_wr_biten,
  input  logic              s_cpuif_req_stall_wr,
  input  logic              s_cpuif_req_stall_rd,
  input  logic              s_cpuif_rd_ack,
  input  logic              s_cpuif_rd_err,
  input  logic [31:0]       s_cpuif_rd_data,
  input  logic              s_cpuif_wr_ack,
  input  logic              s_cpuif_wr_err
);

  state_t      state;
  logic [1:0]  cnt;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic        is_wr_q;
  logic [31:0] rsp_q;
  logic [2:0]  rsp_left;

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        tx_busy;

  logic        stall, ack, err;
  logic        accept, done, bad_cmd;
  logic        gap_hit;

  uart_byte_io #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_io (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .tx_byte (tx_byte),
    .tx_start(tx_start),
    .tx_busy (tx_busy)
  );

  assign stall = is_wr_q ? s_cpuif_req_stall_wr
                         : s_cpuif_req_stall_rd;
  assign ack   = is_wr_q ? s_cpuif_wr_ack : s_cpuif_rd_ack;
  assign err   = is_wr_q ? s_cpuif_wr_err : s_cpuif_rd_err;

  assign accept  = (state == ST_REQ) && !stall;
  assign done    = (accept && ack) ||
                   ((state == ST_WAIT) && ack);
  assign bad_cmd = (state == ST_IDLE) && rx_valid &&
                   (rx_byte != CMD_RD) &&
                   (rx_byte != CMD_WR);

`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
  logic [31:0] gap_cnt;

  // Gap counter reloads on every byte and runs only mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= 32'(GAP_CYC);
    end else if (rx_valid ||
                 !(state == ST_ADDR || state == ST_DATA)) begin
      gap_cnt <= 32'(GAP_CYC);
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 32'd1;
    end
  end

  assign gap_hit = (state == ST_ADDR || state == ST_DATA) &&
                   (gap_cnt == '0);
`else
  wire unused_gap = |GAP_CYC;

  assign gap_hit = 1'b0;
`endif

  // First response byte leaves on the ack; the rest when TX frees.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = RSP_ERR;
    if (bad_cmd) begin
      tx_start = 1'b1;
    end else if (done) begin
      tx_start = 1'b1;
      tx_byte  = err ? RSP_ERR : RSP_OK;
    end else if (state == ST_TX && rsp_left != 3'd0 &&
                 !tx_busy) begin
      tx_start = 1'b1;
      tx_byte  = rsp_q[31:24];
    end
  end

  // Frame parser and single-outstanding CSR transaction FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      is_wr_q  <= 1'b0;
      rsp_q    <= '0;
      rsp_left <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if (bad_cmd) begin
              state    <= ST_TX;
              rsp_left <= '0;
            end else begin
              state   <= ST_ADDR;
              is_wr_q <= (rx_byte == CMD_WR);
              cnt     <= '0;
            end
          end
        end
        ST_ADDR: begin
          if (gap_hit) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            addr_q <= {addr_q[7:0], rx_byte};
            cnt    <= cnt + 2'd1;
            if (cnt == 2'd1) begin
              cnt   <= '0;
              state <= is_wr_q ? ST_DATA : ST_REQ;
            end
          end
        end
        ST_DATA: begin
          if (gap_hit) begin
            state <= ST_IDLE;
          end else if (rx_valid) begin
            wdata_q <= {wdata_q[23:0], rx_byte};
            cnt     <= cnt + 2'd1;
            if (cnt == 2'd3) state <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (done) begin
            state    <= ST_TX;
            rsp_q    <= s_cpuif_rd_data;
            rsp_left <= (!is_wr_q && !err) ? 3'd4 : 3'd0;
          end else if (accept) begin
            state <= ST_WAIT;
          end
        end
        ST_TX: begin
          if (tx_start) begin
            rsp_q    <= {rsp_q[23:0], 8'h00};
            rsp_left <= rsp_left - 3'd1;
          end else if (!tx_busy) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_cpuif_req       = (state == ST_REQ);
  assign s_cpuif_req_is_wr = is_wr_q;
  assign s_cpuif_addr      = ADDR_W'(addr_q);
  assign s_cpuif_wr_data   = wdata_q;
  assign s_cpuif_wr_biten  = {32{s_cpuif_req}};

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Bench for uart_csr_bridge: frame-level model plus CSR responder.
// Timeout scenario runs when UART_CSR_BRIDGE_TIMEOUT_EN is defined.
module tb_uart_csr_bridge;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic        req, is_wr;
  logic [15:0] addr;
  logic [31:0] wr_data, biten;
  logic        stall = 1'b0;
  logic        rd_ack = 1'b0, rd_err = 1'b0;
  logic        wr_ack = 1'b0, wr_err = 1'b0;
  logic [31:0] rd_data = '0;

  uart_csr_bridge #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (16),
    .GAP_CYC     (200)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .uart_rx             (uart_rx),
    .uart_tx             (uart_tx),
    .s_cpuif_req         (req),
    .s_cpuif_req_is_wr   (is_wr),
    .s_cpuif_addr        (addr),
    .s_cpuif_wr_data     (wr_data),
    .s_cpuif_wr_biten    (biten),
    .s_cpuif_req_stall_wr(stall),
    .s_cpuif_req_stall_rd(stall),
    .s_cpuif_rd_ack      (rd_ack),
    .s_cpuif_rd_err      (rd_err),
    .s_cpuif_rd_data     (rd_data),
    .s_cpuif_wr_ack      (wr_ack),
    .s_cpuif_wr_err      (wr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        exp_q[$];
  logic [7:0]  exp_rsp[$];
  logic [7:0]  got_q[$];
  int          got_t[$];

  logic [7:0]  fr [8];
  bit          bad [8];
  int          cfg_stall = 0, cfg_lat = 0;
  bit          cfg_err = 0;
  logic [31:0] cfg_rd = '0;
  int          stall_left = 0;
  int          req_cycles = 0, accepts = 0;
  int          tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // CSR responder and per-cycle request checks.
  initial begin
    bit pend = 0, acc_wr = 0, tx_low = 0, req_low = 0;
    bit prev_req = 0;
    int cd = 0;
    logic [15:0] h_a;
    logic [31:0] h_d;
    logic h_w;
    txn_t t;
    forever begin
      @(negedge clk);
      rd_ack = 0; wr_ack = 0; rd_err = 0; wr_err = 0;
      if (tx_low) begin
        chk("tx_start_after_ack", uart_tx, 0);
        tx_low = 0;
      end
      if (req_low) begin
        chk("req_drop_after_accept", req, 0);
        req_low = 0;
      end
      if (pend) begin
        if (cd == 0) begin
          pend = 0;
          if (acc_wr) begin wr_ack = 1; wr_err = cfg_err; end
          else begin rd_ack = 1; rd_err = cfg_err; end
          rd_data = cfg_rd;
          tx_low = 1;
        end else cd--;
      end
      if (req) begin
        req_cycles++;
        chk("biten", biten, 32'hFFFF_FFFF);
        if (prev_req) begin
          chk("addr_stable", addr, h_a);
          chk("data_stable", wr_data, h_d);
          chk("is_wr_stable", is_wr, h_w);
        end
        h_a = addr; h_d = wr_data; h_w = is_wr;
        if (stall_left > 0) begin
          stall = 1;
          stall_left--;
        end else begin
          stall = 0;
          accepts++;
          req_low = 1;
          acc_wr = is_wr;
          chk("unexpected_req", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            t = exp_q.pop_front();
            chk("req_is_wr", is_wr, t.wr);
            chk("req_addr", addr, t.a);
            if (t.wr) chk("req_wr_data", wr_data, t.d);
          end
          if (cfg_lat == 0) begin
            if (acc_wr) begin wr_ack = 1; wr_err = cfg_err; end
            else begin rd_ack = 1; rd_err = cfg_err; end
            rd_data = cfg_rd;
            tx_low = 1;
          end else begin
            pend = 1;
            cd = cfg_lat - 1;
          end
        end
      end else begin
        stall = 0;
      end
      prev_req = req;
    end
  end

  // Host-side UART receiver for the response stream.
  initial begin
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge uart_tx);
      t0 = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (CPB) @(negedge clk);
      got_q.push_back(b);
      got_t.push_back(t0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stopv);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stopv;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (!stopv) repeat (2 * CPB) @(negedge clk);
  endtask

  // Frame-level model: good bytes form the frame, CSR config decides.
  task automatic model_frame(input int n);
    logic [7:0] c[$];
    txn_t t;
    exp_rsp.delete();
    for (int i = 0; i < n; i++) if (!bad[i]) c.push_back(fr[i]);
    if (c[0] == 8'h52 || c[0] == 8'h57) begin
      t.wr = (c[0] == 8'h57);
      t.a  = {c[1], c[2]};
      t.d  = t.wr ? {c[3], c[4], c[5], c[6]} : 32'h0;
      exp_q.push_back(t);
      if (cfg_err) exp_rsp.push_back(8'h45);
      else begin
        exp_rsp.push_back(8'h4B);
        if (!t.wr)
          for (int k = 3; k >= 0; k--)
            exp_rsp.push_back(cfg_rd[8*k +: 8]);
      end
    end else begin
      exp_rsp.push_back(8'h45);
    end
  endtask

  task automatic run_frame(input string nm, input int n);
    model_frame(n);
    stall_left = cfg_stall;
    got_q.delete();
    got_t.delete();
    for (int i = 0; i < n; i++) send_byte(fr[i], !bad[i]);
    for (int i = 0; i < 4000 && got_q.size() < exp_rsp.size(); i++)
      @(negedge clk);
    chk({nm, "_rsp_count"}, got_q.size(), exp_rsp.size());
    for (int i = 0; i < exp_rsp.size() && i < got_q.size(); i++)
      chk({nm, "_rsp_byte"}, got_q[i], exp_rsp[i]);
    chk({nm, "_txn_done"}, exp_q.size(), 0);
    repeat (20 * CPB) @(negedge clk);
    chk({nm, "_no_extra"}, got_q.size(), exp_rsp.size());
    for (int i = 0; i < 8; i++) bad[i] = 0;
  endtask

  initial begin
    int rc0;
    #5_000_000;
    $display("FAIL watchdog actual=%0d required=<limit>", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rc0, ac0;
    for (int i = 0; i < 8; i++) bad[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_req", req, 0);
    chk("rst_is_wr", is_wr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_biten", biten, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    fr = '{8'h57, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    cfg_stall = 0; cfg_lat = 0; cfg_err = 0; cfg_rd = '0;
    ac0 = accepts;
    run_frame("write", 7);
    chk("write_accepts", accepts - ac0, 1);
    chk("write_rsp_lit", got_q[0], 8'h4B);

    fr = '{8'h52, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cfg_stall = 5; cfg_lat = 3; cfg_rd = 32'h1234_5678;
    rc0 = req_cycles;
    run_frame("read_stall", 3);
    chk("read_req_cycles", req_cycles - rc0, 6);
    chk("read_byte1_lit", got_q[1], 8'h12);
    chk("read_byte4_lit", got_q[4], 8'h78);
    chk("read_b2b_gap", got_t[1] - got_t[0], 10 * CPB);
    chk("read_b2b_gap4", got_t[4] - got_t[3], 10 * CPB);

    fr = '{8'h52, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cfg_stall = 0; cfg_lat = 1; cfg_err = 1; cfg_rd = 32'hA5A5_A5A5;
    run_frame("read_err", 3);
    chk("read_err_lit", got_q[0], 8'h45);

    fr = '{8'h57, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    cfg_stall = 2; cfg_lat = 0; cfg_err = 1;
    run_frame("write_err", 7);

    fr = '{8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cfg_stall = 0; cfg_lat = 0; cfg_err = 0;
    rc0 = req_cycles;
    run_frame("bad_cmd", 1);
    chk("bad_cmd_no_req", req_cycles - rc0, 0);

    fr = '{8'h57, 8'h00, 8'h40, 8'h99, 8'h01, 8'h02, 8'h03, 8'h04};
    bad[3] = 1;
    cfg_lat = 2;
    model_frame(8);
    chk("model_pin_frame", exp_q[0].d, 32'h0102_0304);
    exp_q.delete();
    bad[3] = 1;
    run_frame("frame_err", 8);

    send_byte(8'h57, 1);
    send_byte(8'h00, 1);
    send_byte(8'h10, 1);
    rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx", uart_tx, 1);
    chk("midframe_rst_req", req, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fr = '{8'h52, 8'hBE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cfg_lat = 1; cfg_rd = 32'hCAFE_F00D;
    run_frame("after_rst", 3);

    send_byte(8'h33, 1);
    for (int i = 0; i < 200 && uart_tx; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk("tx_mid_low", uart_tx, 0);
    rst_n = 1'b0;
    #1;
    chk("tx_high_on_reset", uart_tx, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30 * CPB) @(negedge clk);
    got_q.delete();

`ifdef UART_CSR_BRIDGE_TIMEOUT_EN
    send_byte(8'h57, 1);
    send_byte(8'h00, 1);
    repeat (300) @(negedge clk);
    fr = '{8'h52, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    cfg_lat = 0; cfg_rd = 32'h0BAD_BEEF;
    ac0 = accepts;
    run_frame("timeout", 3);
    chk("timeout_one_req", accepts - ac0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
